shift_register_sequencer: RTL and testbench
===========================================

// Module: shift_register_sequencer
// PURPOSE
//  Command-driven controller directly upstream of the 4-bit universal shift register.
//  Accepts one command per valid/ready handshake: hold, parallel load, or N-bit serial shift.
//  Drives the register's mode select, serial inputs and parallel data cycle by cycle, then pulses done.
//  Lets a host move words in and out of the register without timing the select lines itself.
// PARAMETERS
//  WIDTH  4  shift register width; also the width of cmd_data and par_in
//  CNT_W  3  width of cmd_count; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk         in   1      system clock; all logic is rising-edge
//  rst         in   1      synchronous, active-high reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      sequencer can accept a command
//  cmd_op      in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//  cmd_count   in   CNT_W  number of shift cycles (shift ops only)
//  cmd_data    in   WIDTH  load word (op 11) or serial bit stream, LSB first (ops 01/10)
//  s           out  2      register mode select: 00 latch, 01 right, 10 left, 11 load
//  sir         out  1      serial input into the MSB during a right shift
//  sil         out  1      serial input into the LSB during a left shift
//  par_in      out  WIDTH  parallel load data
//  busy        out  1      command in progress (LOAD, SHIFT or DONE state)
//  done        out  1      one-cycle pulse when a command completes
// BEHAVIOUR
//  - All outputs are registered. Reset values: s=00, sir=0, sil=0, par_in=0, busy=0, done=0, cmd_ready=1.
//  - FSM states: IDLE, LOAD, SHIFT, DONE.
//  - cmd_ready=1 only in IDLE. A command is accepted on a rising edge where cmd_valid && cmd_ready.
//  - On accept, cmd_op, cmd_count and cmd_data are latched. Later input changes have no effect.
//  - IDLE -> LOAD on op 11.
//  - IDLE -> SHIFT on op 01/10 with count>0.
//  - IDLE -> DONE on op 00, or on a shift op with count=0.
//  - LOAD: lasts exactly one cycle, with s=11 and par_in=latched data. Then -> DONE.
//  - SHIFT: lasts exactly count cycles, with s=01 (right) or 10 (left).
//    - On shift cycle i (0-based), the active serial line carries data[i] if i<WIDTH, else 0.
//    - The inactive serial line is held at 0.
//    - After the last shift cycle -> DONE.
//  - DONE: lasts one cycle, with s=00 and done=1. Then -> IDLE, where cmd_ready=1 again.
//  - s=00, sir=0, sil=0 in IDLE and DONE. par_in holds its last value except during LOAD.
//  - Latency from the accept edge T:
//    - first active s is in the cycle after T;
//    - done rises one cycle after the last active cycle;
//    - cmd_ready rises the cycle after done.
//  - Back-to-back: with cmd_valid held high, the next command is accepted on the first edge in IDLE.
//    Commands are never overlapped.
//  - Counter: internal shift counter is CNT_W bits and counts down to 1. No wrap is possible.
//  - Reset mid-operation: on the next cycle, s=00, state=IDLE, done=0, and no done pulse is generated.
//    The downstream register keeps its partially shifted contents.
//  - cmd_valid asserted in LOAD, SHIFT or DONE is ignored, not queued.
// TESTING
//  Drive the real universal shift register from these outputs and check its out[3:0]. Reg starts 0000.
//  1. Parallel load: op=11, data=1010.
//     -> s=11 for exactly 1 cycle; out=1010; done 1 cycle later.
//  2. Left shift: op=10, count=3, data=0101, from reg 0000.
//     -> sil sequence 1,0,1; out 0001, 0010, 0101; done after the 3rd shift.
//  3. Right shift: op=01, count=2, data=0011, from reg 1010.
//     -> sir sequence 1,1; out 1101 then 1110; s=00 afterwards.
//  4. Zero count: op=01, count=0.
//     -> no cycle with s!=00; done the cycle after accept; out unchanged.
//  5. Count > WIDTH: op=10, count=5, data=1111.
//     -> sil sequence 1,1,1,1,0; final out=1110; busy high for 6 cycles.
//  6. Reset after 2 of 4 shifts: assert rst.
//     -> next cycle s=00, cmd_ready=1, no done pulse; out holds its 2-shift value; next command accepted normally.

Source files
------------

// File: rtl/shift_register_sequencer.sv
// Command sequencer for a 4-bit universal shift register.
// Turns hold/load/shift commands into cycle-accurate mode and serial-data drive.
module shift_register_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       s,
    output logic             sir,
    output logic             sil,
    output logic [WIDTH-1:0] par_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_LEFT  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [1:0]       s_q, s_d;
    logic             sir_q, sir_d;
    logic             sil_q, sil_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             bit_d;

    // Outputs are registered from the next state, so the first active
    // cycle lands directly after the accept edge.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        par_d   = par_q;
        s_d     = OP_HOLD;
        bit_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_count;
                    data_d = cmd_data;
                    if (cmd_op == OP_LOAD) begin
                        state_d = LOAD;
                        s_d     = OP_LOAD;
                        par_d   = cmd_data;
                    end else if ((cmd_op == OP_RIGHT || cmd_op == OP_LEFT)
                                 && cmd_count != '0) begin
                        state_d = SHIFT;
                        s_d     = cmd_op;
                        bit_d   = cmd_data[0];
                        data_d  = cmd_data >> 1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                state_d = DONE;
            end
            SHIFT: begin
                // Data drains LSB first and back-fills zeros past WIDTH.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    s_d    = op_q;
                    bit_d  = data_q[0];
                    data_d = data_q >> 1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        sir_d   = (s_d == OP_RIGHT) && bit_d;
        sil_d   = (s_d == OP_LEFT) && bit_d;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            par_q   <= '0;
            s_q     <= OP_HOLD;
            sir_q   <= 1'b0;
            sil_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            s_q     <= s_d;
            sir_q   <= sir_d;
            sil_q   <= sil_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign s         = s_q;
    assign sir       = sir_q;
    assign sil       = sil_q;
    assign par_in    = par_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Bench: sequencer driving a behavioural 4-bit universal shift register,
// directed commands with hand-computed register contents.
module tb_shift_register_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_count;
    logic [3:0] cmd_data;
    logic [1:0] s;
    logic       sir;
    logic       sil;
    logic [3:0] par_in;
    logic       busy;
    logic       done;

    logic [3:0] sr_q = 4'b0000;

    int total = 0;
    int bad   = 0;

    logic [1:0] s_log[32];
    logic       sir_log[32];
    logic       sil_log[32];
    logic       busy_log[32];
    logic       done_log[32];
    logic       rdy_log[32];
    logic [3:0] out_log[32];
    int         nlog;

    always #5 clk = ~clk;

    shift_register_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .s         (s),
        .sir       (sir),
        .sil       (sil),
        .par_in    (par_in),
        .busy      (busy),
        .done      (done)
    );

    // Downstream universal shift register; never reset by the sequencer.
    always_ff @(posedge clk) begin
        case (s)
            2'b01:   sr_q <= {sir, sr_q[3:1]};
            2'b10:   sr_q <= {sr_q[2:0], sil};
            2'b11:   sr_q <= par_in;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data);
        int w;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = 3'd7;
        cmd_data  = 4'b1001;
    endtask

    // Log each cycle after accept until one cycle past done.
    task automatic capture();
        logic seen;
        seen = 1'b0;
        nlog = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s_log[k]    = s;
            sir_log[k]  = sir;
            sil_log[k]  = sil;
            busy_log[k] = busy;
            done_log[k] = done;
            rdy_log[k]  = cmd_ready;
            out_log[k]  = sr_q;
            nlog        = k + 1;
            if (seen) break;
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int nb;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = 3'd0;
        cmd_data  = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_sir_sil", 32'({sir, sil}), 32'd0);
        chk("rst_par", 32'(par_in), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // 1: parallel load 1010
        issue(2'b11, 3'd0, 4'b1010);
        capture();
        chk("t1_s0", 32'(s_log[0]), 32'd3);
        chk("t1_par", 32'(par_in), 32'hA);
        chk("t1_rdy0", 32'(rdy_log[0]), 32'd0);
        chk("t1_s1", 32'(s_log[1]), 32'd0);
        chk("t1_done1", 32'(done_log[1]), 32'd1);
        chk("t1_out", 32'(out_log[1]), 32'hA);
        chk("t1_rdy2", 32'(rdy_log[2]), 32'd1);
        chk("t1_len", 32'(nlog), 32'd3);

        // 2: left shift 3 of 0101 from 0000
        rst = 1'b0;
        @(negedge clk);
        issue(2'b11, 3'd0, 4'b0000);
        capture();
        issue(2'b10, 3'd3, 4'b0101);
        capture();
        chk("t2_s", 32'({s_log[0], s_log[1], s_log[2]}), 32'b101010);
        chk("t2_sil", 32'({sil_log[0], sil_log[1], sil_log[2]}), 32'b101);
        chk("t2_sir", 32'({sir_log[0], sir_log[1], sir_log[2]}), 32'b000);
        chk("t2_out", 32'({out_log[1], out_log[2], out_log[3]}), 32'h125);
        chk("t2_done", 32'({done_log[2], done_log[3]}), 32'b01);

        // 3: right shift 2 of 0011 from 1010
        issue(2'b11, 3'd0, 4'b1010);
        capture();
        issue(2'b01, 3'd2, 4'b0011);
        capture();
        chk("t3_s", 32'({s_log[0], s_log[1], s_log[2]}), 32'b010100);
        chk("t3_sir", 32'({sir_log[0], sir_log[1]}), 32'b11);
        chk("t3_sil", 32'({sil_log[0], sil_log[1]}), 32'b00);
        chk("t3_out", 32'({out_log[1], out_log[2]}), 32'hDE);
        chk("t3_done", 32'(done_log[2]), 32'd1);

        // 4: zero-count shift
        issue(2'b01, 3'd0, 4'b1111);
        capture();
        chk("t4_s", 32'(s_log[0]), 32'd0);
        chk("t4_done", 32'(done_log[0]), 32'd1);
        chk("t4_out", 32'(out_log[1]), 32'hE);
        chk("t4_rdy", 32'(rdy_log[1]), 32'd1);

        // 5: count past WIDTH back-fills zero
        issue(2'b10, 3'd5, 4'b1111);
        capture();
        chk("t5_sil", 32'({sil_log[0], sil_log[1], sil_log[2],
                           sil_log[3], sil_log[4]}), 32'b11110);
        chk("t5_s4", 32'(s_log[4]), 32'd2);
        chk("t5_out", 32'(out_log[5]), 32'hE);
        chk("t5_done", 32'(done_log[5]), 32'd1);
        nb = 0;
        for (int k = 0; k < nlog; k++) nb += int'(busy_log[k]);
        chk("t5_busy", 32'(nb), 32'd6);

        // 6: reset after 2 of 4 left shifts of 0011 from 1110
        issue(2'b10, 3'd4, 4'b0011);
        @(negedge clk);
        @(negedge clk);
        chk("t6_mid", 32'(sr_q), 32'hD);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_s", 32'(s), 32'd0);
        chk("t6_rdy", 32'(cmd_ready), 32'd1);
        chk("t6_done", 32'({done, busy}), 32'd0);
        @(negedge clk);
        chk("t6_done2", 32'(done), 32'd0);
        chk("t6_out", 32'(sr_q), 32'hB);
        issue(2'b11, 3'd0, 4'b0110);
        capture();
        chk("t6_reload", 32'(out_log[1]), 32'h6);
        chk("t6_rdone", 32'(done_log[1]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
